// File: rtl/cordic_pkg.sv
// Shared widths, constants, state encoding and arctangent table for the
// vectoring-mode CORDIC block.
package cordic_pkg;

    localparam int DATA_W     = 14;
    localparam int INT_W      = 17;
    localparam int ANG_W      = 16;
    localparam int CNT_W      = 4;
    localparam int ITERATIONS = 15;
    localparam int HALF_PI    = 23052;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    // atan(2^-i) in units where 23052 == pi/2
    function automatic logic signed [INT_W-1:0] atan_lut(input logic [CNT_W-1:0] i);
        case (i)
            4'd0:    return 17'sd11526;
            4'd1:    return 17'sd6804;
            4'd2:    return 17'sd3595;
            4'd3:    return 17'sd1825;
            4'd4:    return 17'sd916;
            4'd5:    return 17'sd458;
            4'd6:    return 17'sd229;
            4'd7:    return 17'sd114;
            4'd8:    return 17'sd57;
            4'd9:    return 17'sd28;
            4'd10:   return 17'sd14;
            4'd11:   return 17'sd7;
            4'd12:   return 17'sd3;
            4'd13:   return 17'sd2;
            4'd14:   return 17'sd1;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/vec_rotator.sv
// One vectoring micro-rotation: drives y toward zero and accumulates the
// rotated angle in z.
module vec_rotator
    import cordic_pkg::*;
(
    input  logic signed [INT_W-1:0] x,
    input  logic signed [INT_W-1:0] y,
    input  logic signed [INT_W-1:0] z,
    input  logic        [CNT_W-1:0] i,
    output logic signed [INT_W-1:0] x_nxt,
    output logic signed [INT_W-1:0] y_nxt,
    output logic signed [INT_W-1:0] z_nxt
);

    logic signed [INT_W-1:0] x_sh;
    logic signed [INT_W-1:0] y_sh;
    logic signed [INT_W-1:0] ang;

    assign x_sh = x >>> i;
    assign y_sh = y >>> i;
    assign ang  = atan_lut(i);

    always_comb begin
        if (!y[INT_W-1]) begin
            x_nxt = x + y_sh;
            y_nxt = y - x_sh;
            z_nxt = z + ang;
        end else begin
            x_nxt = x - y_sh;
            y_nxt = y + x_sh;
            z_nxt = z - ang;
        end
    end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring CORDIC: folds (Xin, Yin) into quadrant 0, runs 15
// micro-rotations and reports scaled magnitude, in-quadrant phase and quadrant.
module cordic_vector
    import cordic_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] Xin,
    input  logic signed [DATA_W-1:0] Yin,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic        [ANG_W-1:0]  mag_out,
    output logic        [ANG_W-1:0]  phase_out,
    output logic        [1:0]        quart_out,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERATIONS - 1);

    state_t state, state_nxt;

    logic signed [INT_W-1:0] x, y, z;
    logic signed [INT_W-1:0] x_nxt, y_nxt, z_nxt;
    logic signed [INT_W-1:0] x_ext, y_ext, x_fold, y_fold;
    logic        [CNT_W-1:0] i;
    logic        [1:0]       quart, quad;
    logic                    zero;

    // z would otherwise accumulate the whole LUT for a zero vector
    function automatic logic [ANG_W-1:0] sat_phase(input logic signed [INT_W-1:0] ang,
                                                   input logic is_zero);
        if (is_zero || ang[INT_W-1]) return '0;
        if (ang > INT_W'(HALF_PI)) return ANG_W'(HALF_PI);
        return ang[ANG_W-1:0];
    endfunction

    vec_rotator u_rot (
        .x     (x),
        .y     (y),
        .z     (z),
        .i     (i),
        .x_nxt (x_nxt),
        .y_nxt (y_nxt),
        .z_nxt (z_nxt)
    );

    assign x_ext = {{(INT_W-DATA_W){Xin[DATA_W-1]}}, Xin};
    assign y_ext = {{(INT_W-DATA_W){Yin[DATA_W-1]}}, Yin};

    always_comb begin
        quad   = QUAD_0;
        x_fold = x_ext;
        y_fold = y_ext;
        case ({Xin[DATA_W-1], Yin[DATA_W-1]})
            2'b10: begin quad = QUAD_1; x_fold = y_ext;  y_fold = -x_ext; end
            2'b11: begin quad = QUAD_2; x_fold = -x_ext; y_fold = -y_ext; end
            2'b01: begin quad = QUAD_3; x_fold = -y_ext; y_fold = x_ext;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)       state_nxt = ITER;
            ITER:    if (i == LAST_ITER) state_nxt = DONE;
            DONE:    if (out_ready)      state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            quart     <= '0;
            zero      <= 1'b0;
            mag_out   <= '0;
            phase_out <= '0;
            quart_out <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x     <= x_fold;
                    y     <= y_fold;
                    z     <= '0;
                    i     <= '0;
                    quart <= quad;
                    zero  <= (Xin == '0) && (Yin == '0);
                end
                ITER: begin
                    x <= x_nxt;
                    y <= y_nxt;
                    z <= z_nxt;
                    i <= i + 1'b1;
                    if (i == LAST_ITER) begin
                        mag_out   <= x_nxt[ANG_W-1:0];
                        phase_out <= sat_phase(z_nxt, zero);
                        quart_out <= quart;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
